// File: rtl/tb_run_sequencer.sv
// tb_run_sequencer: turns host start/abort/clear commands into the reset -> enable -> drain -> freeze run sequence.
// Optional stall watchdog in RUN is built when RUN_WATCHDOG_EN is defined.
module tb_run_sequencer #(
   parameter int WIDTH        = 32,
   parameter int RST_CYCLES   = 4,
   parameter int DRAIN_CYCLES = 8,
   parameter int WD_CYCLES    = 256
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_len,
   input  logic [WIDTH-1:0] i_data_ctr,
   output logic             tb_reset,
   output logic             tb_enable,
   output logic             tb_freeze,
   output logic [2:0]       state,
   output logic             done,
   output logic             aborted,
   output logic             wd_trip,
   output logic             cmd_err,
   output logic [WIDTH-1:0] run_cycles,
   output logic [WIDTH-1:0] result_data_ctr
);
   typedef enum logic [2:0] {S_IDLE = 3'd0, S_RESET = 3'd1, S_RUN = 3'd2, S_DRAIN = 3'd3, S_DONE = 3'd4} state_e;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] RST_LAST = WIDTH'(RST_CYCLES - 1);
   localparam logic [WIDTH-1:0] DRAIN_LAST = WIDTH'(DRAIN_CYCLES - 1);
   state_e state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d, len_q, len_d, run_q, run_d, result_q, result_d;
   logic done_q, done_d, aborted_q, aborted_d, wd_q, wd_d, err_q, err_d;
   logic tb_reset_q, tb_enable_q, tb_freeze_q, ready_q;
   logic start, abort, clear, busy, wd_hit;
   assign start = cmd_valid && cmd_op == 2'b01;
   assign abort = cmd_valid && cmd_op == 2'b10;
   assign clear = cmd_valid && cmd_op == 2'b11;
   assign busy = state_q inside {S_RESET, S_RUN, S_DRAIN};
`ifdef RUN_WATCHDOG_EN
   localparam logic [WIDTH-1:0] WD_LAST = WIDTH'(WD_CYCLES - 1);
   logic [WIDTH-1:0] stall_q, prev_q;
   logic stalled;
   // Stall count restarts on any data movement and whenever we are outside RUN.
   assign stalled = state_q == S_RUN && i_data_ctr == prev_q;
   assign wd_hit = stalled && stall_q == WD_LAST;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
         prev_q <= '0;
      end else begin
         stall_q <= stalled ? stall_q + ONE : '0;
         prev_q <= i_data_ctr;
      end
   end
`else
   assign wd_hit = WD_CYCLES < 0;
`endif
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      len_d = len_q;
      run_d = run_q;
      result_d = result_q;
      done_d = done_q;
      aborted_d = aborted_q;
      wd_d = wd_q;
      err_d = err_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RESET;
               cnt_d = '0;
               len_d = cmd_len;
               run_d = '0;
               done_d = 1'b0;
               aborted_d = 1'b0;
               wd_d = 1'b0;
               err_d = 1'b0;
            end else if (clear) begin
               err_d = 1'b0;
               if (state_q == S_DONE) begin
                  state_d = S_IDLE;
                  run_d = '0;
                  result_d = '0;
                  done_d = 1'b0;
                  aborted_d = 1'b0;
                  wd_d = 1'b0;
               end
            end
         end
         S_RESET: begin
            cnt_d = cnt_q == RST_LAST ? '0 : cnt_q + ONE;
            if (cnt_q == RST_LAST) state_d = len_q == '0 ? S_DRAIN : S_RUN;
         end
         S_RUN: begin
            run_d = &run_q ? run_q : run_q + ONE;
            cnt_d = cnt_q == len_q - ONE ? '0 : cnt_q + ONE;
            if (cnt_q == len_q - ONE) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            cnt_d = cnt_q + ONE;
            if (cnt_q == DRAIN_LAST) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      if (busy) begin
         if (start || clear) err_d = 1'b1;
         if (wd_hit) begin
            state_d = S_DONE;
            wd_d = 1'b1;
         end
         // Abort outranks both a normal phase end and a watchdog trip.
         if (abort) begin
            state_d = S_DONE;
            aborted_d = 1'b1;
            wd_d = 1'b0;
         end
      end
      if (state_d == S_DONE && state_q != S_DONE) begin
         result_d = i_data_ctr;
         done_d = 1'b1;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         len_q <= '0;
         run_q <= '0;
         result_q <= '0;
         done_q <= 1'b0;
         aborted_q <= 1'b0;
         wd_q <= 1'b0;
         err_q <= 1'b0;
         tb_reset_q <= 1'b0;
         tb_enable_q <= 1'b0;
         tb_freeze_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         len_q <= len_d;
         run_q <= run_d;
         result_q <= result_d;
         done_q <= done_d;
         aborted_q <= aborted_d;
         wd_q <= wd_d;
         err_q <= err_d;
         tb_reset_q <= state_d == S_RESET;
         tb_enable_q <= state_d == S_RUN;
         tb_freeze_q <= state_d == S_DONE;
         ready_q <= state_d == S_IDLE || state_d == S_DONE;
      end
   end
   assign state = state_q;
   assign cmd_ready = ready_q;
   assign tb_reset = tb_reset_q;
   assign tb_enable = tb_enable_q;
   assign tb_freeze = tb_freeze_q;
   assign done = done_q;
   assign aborted = aborted_q;
   assign wd_trip = wd_q;
   assign cmd_err = err_q;
   assign run_cycles = run_q;
   assign result_data_ctr = result_q;
endmodule
